// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
//   Watches a multiplexed 7-segment scan bus and rebuilds the 4-digit BCD
//   value being shown. Each digit slot is sampled once its drive has been
//   stable for SETTLE_CYCLES. The four slots are collected into shadow
//   registers, and each complete frame is then published in one step.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   seg_in[7:0]  segment drive, active-low; [7]=a .. [1]=g, [0]=dp
//   digit_in[3:0] digit select, one-hot active-high; [0]=ones .. [3]=thousands
//   bcd_out[15:0] last complete frame; [3:0]=ones .. [15:12]=thousands
//   dp_out[3:0]  decimal points of the last frame, 1 = lit
//   frame_valid  one-cycle pulse in the cycle bcd_out/dp_out take a new frame
//   pattern_err  one-cycle pulse on a sample with an unknown pattern or a
//                digit select that is not one-hot
//   stale        level, high while no frame has completed for TIMEOUT_CYCLES
//
// Output handshake: frame_valid is a valid-only strobe with no ready. A
// consumer must capture bcd_out/dp_out in the cycle frame_valid is high.
// The data is then held until the next pulse.
module seg7_scan_decoder #(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 250000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  seg_in,
    input  logic [3:0]  digit_in,
    output logic [15:0] bcd_out,
    output logic [3:0]  dp_out,
    output logic        frame_valid,
    output logic        pattern_err,
    output logic        stale
);

    localparam logic [7:0]  SETTLE_MAX = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0]  SAMPLE_AT  = 8'(SETTLE_CYCLES - 2);
    localparam logic [19:0] TMO_MAX    = 20'(TIMEOUT_CYCLES);

    logic [11:0] cur;          // {seg, digit} as registered this cycle
    logic [11:0] prev;         // cur one cycle earlier
    logic [7:0]  stab_cnt;
    logic [15:0] shadow_bcd;
    logic [3:0]  shadow_dp;
    logic [3:0]  mask;
    logic [19:0] tmo_cnt;

    logic        stable;
    logic        sample;
    logic        onehot;
    logic        pat_bad;
    logic [3:0]  nibble;
    logic        dp_bit;
    logic        wr_slot;
    logic        frame_done;

    assign stable = (cur == prev);
    // Fires only on the step to SETTLE_MAX. The counter then saturates,
    // so each stable interval gives at most one sample.
    assign sample = stable && (stab_cnt == SAMPLE_AT);
    assign onehot = (cur[3:0] != 4'b0000) && ((cur[3:0] & (cur[3:0] - 4'd1)) == 4'b0000);
    assign dp_bit = ~cur[4];
    assign wr_slot = sample && onehot;
    // Samples are at least SETTLE_CYCLES apart, so a completed mask is never
    // seen together with a new sample.
    assign frame_done = (mask == 4'b1111);
    assign stale = (tmo_cnt == TMO_MAX);

    // Pattern decode on a..g (cur[11:5]), active-low.
    always_comb begin
        nibble  = 4'hE;
        pat_bad = 1'b0;
        case (cur[11:5])
            7'b0000001: nibble = 4'h0;
            7'b1001111: nibble = 4'h1;
            7'b0010010: nibble = 4'h2;
            7'b0000110: nibble = 4'h3;
            7'b1001100: nibble = 4'h4;
            7'b0100100: nibble = 4'h5;
            7'b0100000: nibble = 4'h6;
            7'b0001111: nibble = 4'h7;
            7'b0000000: nibble = 4'h8;
            7'b0000100: nibble = 4'h9;
            7'b1111110: nibble = 4'hA;   // dash, only g lit
            7'b1111111: nibble = 4'hB;   // blank
            default: begin
                nibble  = 4'hE;
                pat_bad = 1'b1;
            end
        endcase
    end

    // Input capture and stability counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur      <= 12'd0;
            prev     <= 12'd0;
            stab_cnt <= 8'd0;
        end else begin
            cur  <= {seg_in, digit_in};
            prev <= cur;
            if (!stable)
                stab_cnt <= 8'd0;
            else if (stab_cnt != SETTLE_MAX)
                stab_cnt <= stab_cnt + 8'd1;
        end
    end

    // Shadow slots and collected mask. A repeat sample of a slot overwrites it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_bcd <= 16'd0;
            shadow_dp  <= 4'd0;
            mask       <= 4'd0;
        end else begin
            if (wr_slot) begin
                for (int i = 0; i < 4; i++) begin
                    if (cur[i]) begin
                        shadow_bcd[4*i +: 4] <= nibble;
                        shadow_dp[i]         <= dp_bit;
                    end
                end
            end
            if (frame_done)
                mask <= 4'd0;
            else if (wr_slot)
                mask <= mask | cur[3:0];
        end
    end

    // Frame publish, error strobe and scan timeout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd_out     <= 16'd0;
            dp_out      <= 4'd0;
            frame_valid <= 1'b0;
            pattern_err <= 1'b0;
            tmo_cnt     <= 20'd0;
        end else begin
            frame_valid <= frame_done;
            pattern_err <= sample && (pat_bad || !onehot);
            if (frame_done) begin
                bcd_out <= shadow_bcd;
                dp_out  <= shadow_dp;
            end
            // Cleared on the same edge that raises frame_valid, so stale
            // drops in the pulse cycle.
            if (frame_done)
                tmo_cnt <= 20'd0;
            else if (tmo_cnt != TMO_MAX)
                tmo_cnt <= tmo_cnt + 20'd1;
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder (SETTLE_CYCLES=16, TIMEOUT_CYCLES=1000).
module tb_seg7_scan_decoder;

    localparam int S     = 16;
    localparam int T     = 1000;
    localparam int DWELL = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  seg_in = 8'hFF;
    logic [3:0]  digit_in = 4'b0000;
    logic [15:0] bcd_out;
    logic [3:0]  dp_out;
    logic        frame_valid;
    logic        pattern_err;
    logic        stale;

    int n_checks = 0;
    int n_fail = 0;
    int frame_cnt = 0;
    int err_cnt = 0;
    logic [19:0] exp_q[$];   // {dp, bcd}

    // clock / reset
    always #5 clk = ~clk;

    seg7_scan_decoder #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk),
        .reset(reset),
        .seg_in(seg_in),
        .digit_in(digit_in),
        .bcd_out(bcd_out),
        .dp_out(dp_out),
        .frame_valid(frame_valid),
        .pattern_err(pattern_err),
        .stale(stale)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] seg7(input logic [3:0] d, input logic dp);
        logic [6:0] p;
        case (d)
            4'h0: p = 7'b0000001;
            4'h1: p = 7'b1001111;
            4'h2: p = 7'b0010010;
            4'h3: p = 7'b0000110;
            4'h4: p = 7'b1001100;
            4'h5: p = 7'b0100100;
            4'h6: p = 7'b0100000;
            4'h7: p = 7'b0001111;
            4'h8: p = 7'b0000000;
            4'h9: p = 7'b0000100;
            4'hA: p = 7'b1111110;
            default: p = 7'b1111111;
        endcase
        return {p, ~dp};
    endfunction

    // driver tasks: all start and end at posedge + #1
    task automatic drive(input logic [7:0] s, input logic [3:0] d);
        seg_in   = s;
        digit_in = d;
    endtask

    task automatic hold(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic show(input logic [7:0] s, input logic [3:0] d, input int n);
        drive(s, d);
        hold(n);
    endtask

    // cycles until frame_valid is seen, bounded at 100
    task automatic wait_frame(output int k);
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!frame_valid && k < 100);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_valid) begin
                frame_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL frame_unexpected: got %0h expected no frame", {dp_out, bcd_out});
                end else begin
                    check("frame", {12'd0, dp_out, bcd_out}, {12'd0, exp_q.pop_front()});
                end
            end
            if (pattern_err) err_cnt++;
        end
    end

    initial begin
        int k;
        drive(8'hFF, 4'b0000);
        reset = 1'b1;
        hold(3);
        check("rst_bcd", bcd_out, 16'h0000);
        check("rst_dp", dp_out, 4'h0);
        check("rst_fv", frame_valid, 1'b0);
        check("rst_err", pattern_err, 1'b0);
        check("rst_stale", stale, 1'b0);

        // idle bus (no digit selected) gets sampled once -> error
        reset = 1'b0;
        hold(30);
        check("idle_err", err_cnt, 1);

        // two scans of 0429 with dash in the thousands slot
        repeat (2) begin
            show(seg7(4'h9, 1'b0), 4'b0001, DWELL);
            show(seg7(4'h2, 1'b0), 4'b0010, DWELL);
            show(seg7(4'h4, 1'b0), 4'b0100, DWELL);
            exp_q.push_back({4'b0000, 16'hA429});
            show(8'b11111101, 4'b1000, DWELL);
        end
        check("dash_frames", frame_cnt, 2);
        check("dash_no_err", err_cnt, 1);

        // 1,2,3,4 with dp on tens
        show(seg7(4'h1, 1'b0), 4'b0001, DWELL);
        show(seg7(4'h2, 1'b1), 4'b0010, DWELL);
        show(seg7(4'h3, 1'b0), 4'b0100, DWELL);
        exp_q.push_back({4'b0010, 16'h4321});
        show(seg7(4'h4, 1'b0), 4'b1000, DWELL);
        check("dp_frames", frame_cnt, 3);

        // glitch immunity on ones, then settle latency
        show(seg7(4'h3, 1'b0), 4'b0010, DWELL);
        show(seg7(4'h0, 1'b0), 4'b0100, DWELL);
        show(8'hFF, 4'b1000, DWELL);
        for (int i = 0; i < 8; i++)
            show((i % 2 == 1) ? seg7(4'h6, 1'b0) : seg7(4'h5, 1'b0), 4'b0001, 8);
        check("glitch_no_frame", frame_cnt, 3);
        check("glitch_no_err", err_cnt, 1);
        exp_q.push_back({4'b0000, 16'hB037});
        drive(seg7(4'h7, 1'b0), 4'b0001);
        wait_frame(k);
        check("settle_latency", k, S + 2);
        hold(10);
        check("glitch_frames", frame_cnt, 4);

        // blank on tens, non-one-hot select, unknown pattern then overwrite
        show(8'hFF, 4'b0010, DWELL);
        show(seg7(4'h8, 1'b0), 4'b0011, 20);
        check("multi_sel_err", err_cnt, 2);
        show(8'b01101101, 4'b0100, DWELL);
        check("bad_pat_err", err_cnt, 3);
        show(seg7(4'h5, 1'b0), 4'b0001, DWELL);
        show(seg7(4'h6, 1'b0), 4'b0100, DWELL);
        exp_q.push_back({4'b0000, 16'h76B5});
        drive(seg7(4'h7, 1'b0), 4'b1000);
        wait_frame(k);
        check("err_frame_latency", k, S + 2);

        // scan stops: stale after T cycles, output held
        k = 0;
        while (!stale && k < 2000) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("stale_latency", k, T);
        check("stale_held_bcd", bcd_out, 16'h76B5);
        hold(50);
        check("stale_level", stale, 1'b1);

        // resume: stale clears with the next frame
        show(seg7(4'h8, 1'b0), 4'b0001, DWELL);
        show(seg7(4'h7, 1'b0), 4'b0010, DWELL);
        show(seg7(4'h6, 1'b0), 4'b0100, DWELL);
        exp_q.push_back({4'b0000, 16'h5678});
        drive(seg7(4'h5, 1'b0), 4'b1000);
        wait_frame(k);
        check("resume_latency", k, S + 2);
        check("resume_stale_clr", stale, 1'b0);
        hold(DWELL);

        // reset after two slots
        show(seg7(4'h1, 1'b0), 4'b0001, DWELL);
        show(seg7(4'h2, 1'b0), 4'b0010, DWELL);
        drive(8'hFF, 4'b0000);
        reset = 1'b1;
        #1;
        check("mid_rst_bcd", bcd_out, 16'h0000);
        check("mid_rst_dp", dp_out, 4'h0);
        check("mid_rst_fv", frame_valid, 1'b0);
        check("mid_rst_err", pattern_err, 1'b0);
        check("mid_rst_stale", stale, 1'b0);
        hold(3);
        reset = 1'b0;
        hold(30);
        check("post_rst_idle_err", err_cnt, 4);
        show(seg7(4'h3, 1'b0), 4'b0100, DWELL);
        show(seg7(4'h4, 1'b0), 4'b1000, DWELL);
        check("post_rst_partial", frame_cnt, 6);
        exp_q.push_back({4'b0000, 16'h4389});
        show(seg7(4'h9, 1'b0), 4'b0001, DWELL);
        show(seg7(4'h8, 1'b0), 4'b0010, DWELL);
        check("post_rst_frame", frame_cnt, 7);

        // final report
        check("queue_empty", exp_q.size(), 0);
        check("total_errs", err_cnt, 4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
